uart_cmd_bridge: RTL and testbench

- Host-side consumer of the UART-with-FIFOs system interface. Pops received bytes from the RX FIFO and parses them as register read/write command frames.
- Issues single-cycle strobes on a simple register bus and pushes a response byte into the TX FIFO.
- Drives rd_uart/wr_uart/w_data; observes rx_empty/r_data/tx_full, i.e. the TEST-side signals of the UART system.

---
 rtl/uart_cmd_bridge.sv | 206 ++++++++++++++++++++
 tb/tb_uart_cmd_bridge.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_bridge.sv
// Register-bus command bridge fed by a UART RX/TX FIFO pair: parses 'W' addr data / 'R' addr frames, answers ACK/data/NAK.
// Optional partial-frame timeout is compiled in with `define UART_BRIDGE_TIMEOUT_EN.
module uart_cmd_bridge #(
  parameter int DBIT           = 8,
  parameter int REG_NUM        = 16,
  parameter int TIMEOUT_CYCLES = 65000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx_empty,
  input  logic [DBIT-1:0] r_data,
  output logic            rd_uart,
  input  logic            tx_full,
  output logic [DBIT-1:0] w_data,
  output logic            wr_uart,
  output logic [7:0]      reg_addr,
  output logic [DBIT-1:0] reg_wdata,
  output logic            reg_we,
  output logic            reg_re,
  input  logic [DBIT-1:0] reg_rdata,
  output logic            busy,
  output logic [7:0]      err_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    ACCESS,
    RD_WAIT,
    SEND
  } state_t;

  localparam logic [DBIT-1:0] CMD_WR   = DBIT'(8'h57);
  localparam logic [DBIT-1:0] CMD_RD   = DBIT'(8'h52);
  localparam logic [DBIT-1:0] RESP_ACK = DBIT'(8'h06);
  localparam logic [DBIT-1:0] RESP_NAK = DBIT'(8'h15);

  state_t          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [7:0]      addr_q, addr_d;
  logic [DBIT-1:0] wdata_q, wdata_d;
  logic [DBIT-1:0] resp_q, resp_d;
  logic            nak_q, nak_d;
  logic [7:0]      err_q, err_d;
  logic            timeout_hit;

  // Widened compare so REG_NUM = 256 accepts every 8-bit address.
  function automatic logic addr_ok(input logic [7:0] a);
    return ({1'b0, a} < 9'(REG_NUM));
  endfunction

`ifdef UART_BRIDGE_TIMEOUT_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;

  assign timeout_hit = (idle_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  // Counts only while starved mid-frame; any pop or state change returns it to zero.
  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == GET_ADDR || state_q == GET_DATA) && rx_empty && !timeout_hit)
      idle_cnt_d = idle_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) idle_cnt_q <= '0;
    else     idle_cnt_q <= idle_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d = state_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    resp_d  = resp_q;
    nak_d   = nak_q;
    err_d   = err_q;
    rd_uart = 1'b0;
    reg_we  = 1'b0;
    reg_re  = 1'b0;
    wr_uart = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          if (r_data == CMD_WR || r_data == CMD_RD) begin
            is_wr_d = (r_data == CMD_WR);
            state_d = GET_ADDR;
          end else begin
            resp_d  = RESP_NAK;
            nak_d   = 1'b1;
            state_d = SEND;
          end
        end
      end

      GET_ADDR: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          addr_d  = 8'(r_data);
          // Writes always take the data byte so a bad address cannot desync framing.
          if (is_wr_q) begin
            state_d = GET_DATA;
          end else if (addr_ok(8'(r_data))) begin
            state_d = ACCESS;
          end else begin
            resp_d  = RESP_NAK;
            nak_d   = 1'b1;
            state_d = SEND;
          end
        end else if (timeout_hit) begin
          resp_d  = RESP_NAK;
          nak_d   = 1'b1;
          state_d = SEND;
        end
      end

      GET_DATA: begin
        if (!rx_empty) begin
          rd_uart = 1'b1;
          wdata_d = r_data;
          if (addr_ok(addr_q)) begin
            state_d = ACCESS;
          end else begin
            resp_d  = RESP_NAK;
            nak_d   = 1'b1;
            state_d = SEND;
          end
        end else if (timeout_hit) begin
          resp_d  = RESP_NAK;
          nak_d   = 1'b1;
          state_d = SEND;
        end
      end

      ACCESS: begin
        if (is_wr_q) begin
          reg_we  = 1'b1;
          resp_d  = RESP_ACK;
          nak_d   = 1'b0;
          state_d = SEND;
        end else begin
          reg_re  = 1'b1;
          state_d = RD_WAIT;
        end
      end

      RD_WAIT: begin
        resp_d  = reg_rdata;
        nak_d   = 1'b0;
        state_d = SEND;
      end

      SEND: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          if (nak_q && err_q != 8'hFF) err_d = err_q + 8'd1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Strobes and FIFO handshakes are suppressed in the reset cycle itself.
    if (rst) begin
      rd_uart = 1'b0;
      reg_we  = 1'b0;
      reg_re  = 1'b0;
      wr_uart = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      nak_q   <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      nak_q   <= nak_d;
      err_q   <= err_d;
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign w_data    = resp_q;
  assign err_cnt   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Scoreboard bench for uart_cmd_bridge: RX FIFO model, register slave, expected TX bytes and register strobes.
module tb_uart_cmd_bridge;

  localparam int DBIT    = 8;
  localparam int REG_NUM = 16;
`ifdef UART_BRIDGE_TIMEOUT_EN
  localparam int TO_CYC  = 10;
`else
  localparam int TO_CYC  = 65000;
`endif

  typedef struct {
    logic [7:0] data;
    int         lat;
  } tx_exp_t;

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } reg_exp_t;

  logic       clk = 1'b0;
  logic       rst, rx_empty, rd_uart, tx_full, wr_uart, reg_we, reg_re, busy;
  logic [7:0] r_data, w_data, reg_addr, reg_wdata, reg_rdata, err_cnt;

  always #5 clk = ~clk;

  uart_cmd_bridge #(.DBIT(DBIT), .REG_NUM(REG_NUM), .TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk(clk), .rst(rst),
    .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .err_cnt(err_cnt)
  );

  int         compared = 0, mismatched = 0;
  int         cyc = 0, pops = 0, last_pop_cyc = 0, exp_err = 0, base = 0;
  logic [7:0] rxq[$];
  tx_exp_t    tx_q[$];
  reg_exp_t   reg_q[$];
  logic [7:0] regs[256];
  logic       pop_pending = 1'b0, rd_pending = 1'b0;
  logic [7:0] rd_addr = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh_rx();
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
  endtask

  // Monitor: samples the settled outputs of each cycle on the falling edge.
  always @(negedge clk) begin : mon
    reg_exp_t e;
    tx_exp_t  t;
    cyc++;
    if (rd_uart) begin
      check("rd_while_empty", 32'(rx_empty), 0);
      pop_pending  = 1'b1;
      pops++;
      last_pop_cyc = cyc;
    end
    if (reg_we || reg_re) begin
      if (reg_q.size() == 0) begin
        check("unexpected_reg_strobe", reg_q.size(), 1);
      end else begin
        e = reg_q.pop_front();
        check("reg_we", 32'(reg_we), 32'(e.we));
        check("reg_re", 32'(reg_re), 32'(!e.we));
        check("reg_addr", 32'(reg_addr), 32'(e.addr));
        if (e.we) check("reg_wdata", 32'(reg_wdata), 32'(e.wdata));
      end
      if (reg_we) regs[reg_addr] = reg_wdata;
      if (reg_re) begin
        rd_pending = 1'b1;
        rd_addr    = reg_addr;
      end
    end
    if (wr_uart) begin
      check("wr_while_full", 32'(tx_full), 0);
      if (tx_q.size() == 0) begin
        check("unexpected_tx_push", tx_q.size(), 1);
      end else begin
        t = tx_q.pop_front();
        check("tx_byte", 32'(w_data), 32'(t.data));
        if (t.lat >= 0) check("tx_latency", 32'(cyc - last_pop_cyc), 32'(t.lat));
      end
    end
  end

  // RX FIFO and register slave respond just after the edge that consumed/strobed.
  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      void'(rxq.pop_front());
      pop_pending = 1'b0;
    end
    if (rd_pending) begin
      reg_rdata  = regs[rd_addr];
      rd_pending = 1'b0;
    end
    refresh_rx();
  end

  task automatic push_rx(input logic [7:0] b);
    rxq.push_back(b);
    refresh_rx();
  endtask

  task automatic expect_tx(input logic [7:0] d, input int lat);
    tx_exp_t t;
    t.data = d;
    t.lat  = lat;
    tx_q.push_back(t);
  endtask

  task automatic expect_nak(input int lat);
    expect_tx(8'h15, lat);
    if (exp_err < 255) exp_err++;
  endtask

  task automatic expect_reg(input logic we, input logic [7:0] a, input logic [7:0] d);
    reg_exp_t e;
    e.we    = we;
    e.addr  = a;
    e.wdata = d;
    reg_q.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (rxq.size() == 0 && tx_q.size() == 0 && reg_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
    end
    check(tag, 32'(done), 1);
  endtask

  task automatic wait_pops(input int target, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (pops >= target) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 32'(ok), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_uart"},   32'(rd_uart), 0);
    check({tag, "_wr_uart"},   32'(wr_uart), 0);
    check({tag, "_reg_we"},    32'(reg_we), 0);
    check({tag, "_reg_re"},    32'(reg_re), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_w_data"},    32'(w_data), 0);
    check({tag, "_reg_addr"},  32'(reg_addr), 0);
    check({tag, "_reg_wdata"}, 32'(reg_wdata), 0);
    check({tag, "_err_cnt"},   32'(err_cnt), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) regs[i] = 8'hC0 ^ 8'(i);
    rst = 1'b1; tx_full = 1'b0; reg_rdata = 8'h00;
    refresh_rx();

    // Reset with a byte already waiting: nothing may be popped while rst is high.
    push_rx(8'h41);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("in_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    expect_nak(1);
    wait_done("bad_cmd_after_reset_done");
    check("err_cnt_first_nak", 32'(err_cnt), 32'(exp_err));

    // Write 0xA5 to register 3.
    base = pops;
    expect_reg(1'b1, 8'h03, 8'hA5);
    expect_tx(8'h06, 2);
    push_rx(8'h57); push_rx(8'h03); push_rx(8'hA5);
    wait_done("write_done");
    check("write_pops", 32'(pops - base), 3);

    // Read it back.
    expect_reg(1'b0, 8'h03, 8'h00);
    expect_tx(8'hA5, 3);
    push_rx(8'h52); push_rx(8'h03);
    wait_done("read_done");

    // Unknown command byte.
    base = pops;
    expect_nak(1);
    push_rx(8'h41);
    wait_done("bad_cmd_done");
    check("bad_cmd_pops", 32'(pops - base), 1);
    check("err_cnt_bad_cmd", 32'(err_cnt), 32'(exp_err));

    // Out-of-range write consumes all three bytes; following read still parses.
    base = pops;
    expect_nak(1);
    push_rx(8'h57); push_rx(8'h10); push_rx(8'hFF);
    wait_done("oor_write_done");
    check("oor_write_pops", 32'(pops - base), 3);
    check("err_cnt_oor_write", 32'(err_cnt), 32'(exp_err));
    expect_reg(1'b0, 8'h00, 8'h00);
    expect_tx(8'hC0, 3);
    push_rx(8'h52); push_rx(8'h00);
    wait_done("read_after_oor_done");

    // Back-to-back frames at the address boundary.
    expect_reg(1'b1, 8'h0F, 8'h5A);
    expect_tx(8'h06, 2);
    expect_reg(1'b0, 8'h0F, 8'h00);
    expect_tx(8'h5A, 3);
    expect_nak(1);
    push_rx(8'h57); push_rx(8'h0F); push_rx(8'h5A);
    push_rx(8'h52); push_rx(8'h0F);
    push_rx(8'h52); push_rx(8'h10);
    wait_done("boundary_done");
    check("err_cnt_oor_read", 32'(err_cnt), 32'(exp_err));

    // TX backpressure on a completed read with another byte pending in RX.
    tx_full = 1'b1;
    base = pops;
    expect_reg(1'b0, 8'h03, 8'h00);
    expect_tx(8'hA5, -1);
    expect_nak(1);
    push_rx(8'h52); push_rx(8'h03); push_rx(8'h41);
    wait_pops(base + 2, "bp_addr_popped");
    repeat (2) @(posedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_wr_uart", 32'(wr_uart), 0);
      check("bp_rd_uart", 32'(rd_uart), 0);
      check("bp_busy", 32'(busy), 1);
      check("bp_w_data", 32'(w_data), 32'h A5);
    end
    @(posedge clk); #1;
    tx_full = 1'b0;
    @(negedge clk);
    check("bp_push_on_release", 32'(wr_uart), 1);
    wait_done("backpressure_done");
    check("err_cnt_after_bp", 32'(err_cnt), 32'(exp_err));

    // Reset in the middle of a write frame.
    base = pops;
    push_rx(8'h57); push_rx(8'h05);
    wait_pops(base + 2, "midframe_popped");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_err = 0;
    @(negedge clk);
    check_all_zero("after_reset");
    expect_reg(1'b0, 8'h05, 8'h00);
    expect_tx(8'hC5, 3);
    push_rx(8'h52); push_rx(8'h05);
    wait_done("read_after_reset_done");

`ifdef UART_BRIDGE_TIMEOUT_EN
    // A lone command byte is aborted after the idle timeout.
    expect_nak(-1);
    push_rx(8'h52);
    wait_done("timeout_done");
    check("err_cnt_timeout", 32'(err_cnt), 32'(exp_err));
`endif

    // 256 bad bytes saturate the NAK counter.
    for (int i = 0; i < 256; i++) begin
      expect_nak(1);
      push_rx(8'h41);
    end
    wait_done("saturate_done");
    check("err_cnt_saturated", 32'(err_cnt), 255);

    check("tx_scoreboard_drained", tx_q.size(), 0);
    check("reg_scoreboard_drained", reg_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
